frame_transfer_mb_average: RTL and testbench

- Downstream consumer of the frame transfer interface (dest modport).
- Accumulates the RGB24 pixels of each macroblock and emits one per-macroblock average colour, the block type and a size-error flag through a valid/ready result port.
- Reports the end of each frame with a macroblock count.
- Used for thumbnail generation and auto-exposure statistics in the image processing chain.

---
 rtl/P_ImageProcessing.sv | 35 +++
 rtl/tIFrameTransfer.sv | 21 ++
 rtl/mb_channel_accumulator.sv | 39 +++
 rtl/frame_transfer_mb_average.sv | 157 +++++++++++++++
 tb/tb_frame_transfer_mb_average.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/P_ImageProcessing.sv
// Shared image-processing types and helpers: macroblock type, RGB24 channel
// slices and the rounding/clamping average used by macroblock statistics.
package P_ImageProcessing;

  typedef enum logic [1:0] {
    MB_INTRA  = 2'd0,
    MB_INTER  = 2'd1,
    MB_SKIP   = 2'd2,
    MB_DIRECT = 2'd3
  } teMacroBlockType;

  localparam int RGB24_R_MSB = 23;
  localparam int RGB24_R_LSB = 16;
  localparam int RGB24_G_MSB = 15;
  localparam int RGB24_G_LSB = 8;
  localparam int RGB24_B_MSB = 7;
  localparam int RGB24_B_LSB = 0;

  // Widest channel sum supported: 8 bits of pixel plus up to 8 bits of count.
  localparam int SUM_MAX_WIDTH = 16;

  function automatic logic [7:0] fnRgb24Avg(input logic [SUM_MAX_WIDTH-1:0] sum,
                                            input logic [4:0] shift);
    logic [SUM_MAX_WIDTH:0] half;
    logic [SUM_MAX_WIDTH:0] rounded;
    half    = (SUM_MAX_WIDTH+1)'(1) << shift;
    half    = half >> 1;
    rounded = ({1'b0, sum} + half) >> shift;
    if (rounded > (SUM_MAX_WIDTH+1)'(255)) begin
      return 8'hff;
    end
    return rounded[7:0];
  endfunction

endpackage

// File: rtl/tIFrameTransfer.sv
// Frame transfer interface: a source streams RGB24 pixels grouped into
// macroblocks; the destination throttles it with ul1Ready.
interface tIFrameTransfer;
  import P_ImageProcessing::*;

  logic            ul1Active;
  teMacroBlockType eMacroBlockType;
  logic [23:0]     ul24Rgb24Data;
  logic            ul1MacroBlockEnd;
  logic            ul1Ready;

  modport source (
    output ul1Active, eMacroBlockType, ul24Rgb24Data, ul1MacroBlockEnd,
    input  ul1Ready
  );

  modport dest (
    input  ul1Active, eMacroBlockType, ul24Rgb24Data, ul1MacroBlockEnd,
    output ul1Ready
  );
endinterface

// File: rtl/mb_channel_accumulator.sv
// One colour channel of a macroblock: running sum plus the rounded average of
// the sum as it will be after the current beat.
module mb_channel_accumulator
  import P_ImageProcessing::*;
#(
  parameter int L = 6
) (
  input  logic       ul1Clock,
  input  logic       ul1Reset,
  input  logic       beat,
  input  logic       first,
  input  logic       clear,
  input  logic [7:0] pixel,
  output logic [7:0] avg_next
);

  localparam int SW = 8 + L;

  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;

  always_comb begin
    sum_next = first ? SW'(pixel) : sum + SW'(pixel);
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (beat) begin
      sum <= sum_next;
    end
  end

  // Averaging the post-beat sum lets the end beat itself produce the result.
  assign avg_next = fnRgb24Avg(SUM_MAX_WIDTH'(sum_next), 5'(L));

endmodule

// File: rtl/frame_transfer_mb_average.sv
// Per-macroblock average colour of an RGB24 frame stream, with block type,
// size-error flag and an end-of-frame macroblock count.
module frame_transfer_mb_average
  import P_ImageProcessing::*;
#(
  parameter int MB_WIDTH    = 8,
  parameter int MB_HEIGHT   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   ul1Clock,
  input  logic                   ul1Reset,
  tIFrameTransfer.dest           iFrame,
  output logic [23:0]            ul24OutRgbAvg,
  output teMacroBlockType        eOutMacroBlockType,
  output logic                   ul1OutSizeError,
  output logic                   ul1OutValid,
  input  logic                   ul1OutReady,
  output logic                   ul1FrameDone,
  output logic [COUNT_WIDTH-1:0] ulFrameBlockCount
);

  localparam int N  = MB_WIDTH * MB_HEIGHT;
  localparam int L  = $clog2(N);
  localparam int CW = L + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic            ready;
  logic            beat;
  logic            first;
  logic            end_beat;
  logic            abort;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  teMacroBlockType blk_type;
  teMacroBlockType blk_type_next;
  logic [7:0]      avg_r;
  logic [7:0]      avg_g;
  logic [7:0]      avg_b;
  logic [0:0]      state;
  logic [COUNT_WIDTH-1:0] blk_count;

  // Handshakes: a pixel transfers on a clock edge where ul1Active and ul1Ready
  // are both high; a result transfers on an edge where ul1OutValid and
  // ul1OutReady are both high. Input is stalled only while a result waits.
  assign ready          = !ul1Reset && (!ul1OutValid || ul1OutReady);
  assign iFrame.ul1Ready = ready;
  assign beat           = iFrame.ul1Active && ready;
  assign first          = (cnt == '0);
  assign end_beat       = beat && iFrame.ul1MacroBlockEnd;
  assign abort          = (state == ST_ACTIVE) && !iFrame.ul1Active;

  always_comb begin
    cnt_next      = cnt;
    blk_type_next = blk_type;
    if (first) begin
      cnt_next      = CW'(1);
      blk_type_next = iFrame.eMacroBlockType;
    end else if (cnt != CNT_SAT) begin
      cnt_next = cnt + CW'(1);
    end
  end

  mb_channel_accumulator #(.L(L)) u_acc_r (
    .ul1Clock (ul1Clock),
    .ul1Reset (ul1Reset),
    .beat     (beat),
    .first    (first),
    .clear    (end_beat || abort),
    .pixel    (iFrame.ul24Rgb24Data[RGB24_R_MSB:RGB24_R_LSB]),
    .avg_next (avg_r)
  );

  mb_channel_accumulator #(.L(L)) u_acc_g (
    .ul1Clock (ul1Clock),
    .ul1Reset (ul1Reset),
    .beat     (beat),
    .first    (first),
    .clear    (end_beat || abort),
    .pixel    (iFrame.ul24Rgb24Data[RGB24_G_MSB:RGB24_G_LSB]),
    .avg_next (avg_g)
  );

  mb_channel_accumulator #(.L(L)) u_acc_b (
    .ul1Clock (ul1Clock),
    .ul1Reset (ul1Reset),
    .beat     (beat),
    .first    (first),
    .clear    (end_beat || abort),
    .pixel    (iFrame.ul24Rgb24Data[RGB24_B_MSB:RGB24_B_LSB]),
    .avg_next (avg_b)
  );

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      cnt      <= '0;
      blk_type <= MB_INTRA;
    end else if (end_beat || abort) begin
      cnt <= '0;
    end else if (beat) begin
      cnt      <= cnt_next;
      blk_type <= blk_type_next;
    end
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      ul1OutValid        <= 1'b0;
      ul24OutRgbAvg      <= '0;
      eOutMacroBlockType <= MB_INTRA;
      ul1OutSizeError    <= 1'b0;
    end else if (end_beat) begin
      ul1OutValid        <= 1'b1;
      ul24OutRgbAvg      <= {avg_r, avg_g, avg_b};
      eOutMacroBlockType <= blk_type_next;
      ul1OutSizeError    <= (cnt_next != CNT_FULL);
    end else if (ul1OutReady) begin
      ul1OutValid <= 1'b0;
    end
  end

  // Frame FSM; the done pulse carries the block count and resets it.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      state             <= ST_IDLE;
      ul1FrameDone      <= 1'b0;
      ulFrameBlockCount <= '0;
      blk_count         <= '0;
    end else begin
      ul1FrameDone      <= 1'b0;
      ulFrameBlockCount <= '0;
      if (end_beat && (blk_count != '1)) begin
        blk_count <= blk_count + COUNT_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (iFrame.ul1Active) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!iFrame.ul1Active) begin
            state             <= ST_IDLE;
            ul1FrameDone      <= 1'b1;
            ulFrameBlockCount <= blk_count;
            blk_count         <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_transfer_mb_average.sv
// Bench for frame_transfer_mb_average: directed and random frames checked
// against a pixel-list reference model every cycle.
module tb_frame_transfer_mb_average;
  import P_ImageProcessing::*;

  localparam int MBW  = 8;
  localparam int MBH  = 8;
  localparam int CWID = 16;
  localparam int N    = MBW * MBH;
  localparam int L    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  logic bp_en = 1'b0;
  logic [23:0] avg;
  teMacroBlockType otype;
  logic err;
  logic valid;
  logic done;
  logic [CWID-1:0] bcount;

  always #5 clk = ~clk;

  tIFrameTransfer frame_if();

  frame_transfer_mb_average #(
    .MB_WIDTH(MBW), .MB_HEIGHT(MBH), .COUNT_WIDTH(CWID)
  ) dut (
    .ul1Clock           (clk),
    .ul1Reset           (rst),
    .iFrame             (frame_if),
    .ul24OutRgbAvg      (avg),
    .eOutMacroBlockType (otype),
    .ul1OutSizeError    (err),
    .ul1OutValid        (valid),
    .ul1OutReady        (out_ready),
    .ul1FrameDone       (done),
    .ulFrameBlockCount  (bcount)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0]     pix_q[$];
  logic [26:0]     exp_q[$];
  teMacroBlockType cur_type = MB_INTRA;
  logic            m_in_frame = 1'b0;
  int              m_blocks = 0;
  logic            m_done = 1'b0;
  int              m_count = 0;
  logic            m_beat = 1'b0;

  function automatic logic [26:0] block_result();
    int s [3];
    int a;
    logic [26:0] r;
    for (int c = 0; c < 3; c++) s[c] = 0;
    foreach (pix_q[i]) begin
      s[0] += int'(pix_q[i][23:16]);
      s[1] += int'(pix_q[i][15:8]);
      s[2] += int'(pix_q[i][7:0]);
    end
    r[26]    = (pix_q.size() != N);
    r[25:24] = cur_type;
    for (int c = 0; c < 3; c++) begin
      a = ((s[c] % (1 << (8 + L))) + N / 2) >> L;
      if (a > 255) a = 255;
      r[23 - 8*c -: 8] = a[7:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin : model_p
    logic m_ready;
    if (rst) begin
      pix_q.delete();
      exp_q.delete();
      m_in_frame = 1'b0;
      m_blocks   = 0;
      m_done     = 1'b0;
      m_count    = 0;
      m_beat     = 1'b0;
    end else begin
      m_ready = (exp_q.size() == 0) || out_ready;
      m_beat  = frame_if.ul1Active && m_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_beat) begin
        if (pix_q.size() == 0) cur_type = frame_if.eMacroBlockType;
        pix_q.push_back(frame_if.ul24Rgb24Data);
        if (frame_if.ul1MacroBlockEnd) begin
          exp_q.push_back(block_result());
          pix_q.delete();
          if (m_blocks < (1 << CWID) - 1) m_blocks++;
        end
      end
      m_done  = 1'b0;
      m_count = 0;
      if (m_in_frame && !frame_if.ul1Active) begin
        m_done     = 1'b1;
        m_count    = m_blocks;
        m_blocks   = 0;
        m_in_frame = 1'b0;
        pix_q.delete();
      end else if (!m_in_frame && frame_if.ul1Active) begin
        m_in_frame = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("ready", frame_if.ul1Ready, !rst && (exp_q.size() == 0 || out_ready));
    chk("valid", valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("result", {err, otype, avg}, exp_q[0]);
    chk("frame_done", done, m_done);
    if (m_done) chk("block_count", bcount, m_count);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [23:0] pix, input teMacroBlockType t, input logic last);
    int waited;
    waited = 0;
    frame_if.ul1Active        = 1'b1;
    frame_if.ul24Rgb24Data    = pix;
    frame_if.eMacroBlockType  = t;
    frame_if.ul1MacroBlockEnd = last;
    do begin
      @(posedge clk);
      #1;
      waited++;
      if (bp_en && !m_beat) out_ready = 1'($urandom_range(0, 1));
    end while (!m_beat && waited < 200);
    if (!m_beat) begin
      n_vec++;
      n_miss++;
      $display("FAIL beat_timeout: no beat after %0d cycles, required one", waited);
    end
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
    frame_if.ul1MacroBlockEnd = 1'b0;
  endtask

  task automatic send_block(input int nbeats, input logic [23:0] pix,
                            input logic rnd, input logic with_end);
    teMacroBlockType t;
    for (int i = 0; i < nbeats; i++) begin
      t = teMacroBlockType'($urandom_range(0, 3));
      drive(rnd ? 24'($urandom) : pix, t, with_end && (i == nbeats - 1));
    end
  endtask

  task automatic end_frame(input int exp_count);
    int waited;
    waited = 0;
    frame_if.ul1Active        = 1'b0;
    frame_if.ul1MacroBlockEnd = 1'b0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!done && waited < 10);
    chk("done_pulse", done, 1'b1);
    chk("done_count", bcount, exp_count);
    @(posedge clk);
    #1;
    chk("done_width", done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    frame_if.ul1Active        = 1'b0;
    frame_if.ul24Rgb24Data    = '0;
    frame_if.eMacroBlockType  = MB_INTRA;
    frame_if.ul1MacroBlockEnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_avg", avg, 24'h0);
    chk("rst_type", otype, MB_INTRA);
    chk("rst_err", err, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", bcount, 0);
    chk("rst_ready", frame_if.ul1Ready, 1'b0);
    rst = 1'b0;

    // Uniform block, rounding, ramp
    send_block(63, 24'h204060, 1'b0, 1'b0);
    chk("uniform_pre_valid", valid, 1'b0);
    drive(24'h204060, MB_INTER, 1'b1);
    chk("uniform_latency", valid, 1'b1);
    chk("uniform_avg", avg, 24'h204060);
    chk("uniform_err", err, 1'b0);
    send_block(32, 24'h000000, 1'b0, 1'b0);
    send_block(32, 24'h010101, 1'b0, 1'b1);
    chk("round_avg", avg, 24'h010101);
    for (int i = 0; i < 64; i++) drive({8'(i), 16'h0}, MB_SKIP, i == 63);
    chk("ramp_avg", avg, 24'h200000);
    chk("ramp_type", otype, MB_SKIP);
    end_frame(3);

    // Backpressure
    out_ready = 1'b0;
    send_block(64, 24'h0, 1'b1, 1'b1);
    frame_if.ul24Rgb24Data = 24'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready_low", frame_if.ul1Ready, 1'b0);
      chk("bp_valid_held", valid, 1'b1);
    end
    out_ready = 1'b1;
    send_block(64, 24'h0, 1'b1, 1'b1);
    end_frame(2);

    // Size errors
    send_block(10, 24'h400000, 1'b0, 1'b1);
    chk("short_err", err, 1'b1);
    chk("short_avg", avg, 24'h0a0000);
    send_block(70, 24'h0, 1'b1, 1'b1);
    chk("long_err", err, 1'b1);
    send_block(64, 24'h102030, 1'b0, 1'b1);
    chk("clean_err", err, 1'b0);
    chk("clean_avg", avg, 24'h102030);
    end_frame(3);

    // Full frame, then a frame aborted mid-block
    send_block(64, 24'h0, 1'b1, 1'b1);
    send_block(64, 24'h0, 1'b1, 1'b1);
    send_block(64, 24'h0, 1'b1, 1'b1);
    end_frame(3);
    send_block(64, 24'h0, 1'b1, 1'b1);
    send_block(64, 24'h0, 1'b1, 1'b1);
    send_block(64, 24'h0, 1'b1, 1'b1);
    send_block(20, 24'h0, 1'b1, 1'b0);
    end_frame(3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", valid, 1'b0);
    end

    // Random sizes with random backpressure
    bp_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) send_block($urandom_range(1, 80), 24'h0, 1'b1, 1'b1);
      else send_block(64, 24'h0, 1'b1, 1'b1);
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    end_frame(12);

    // Reset with a result pending and a pixel stalled
    out_ready = 1'b0;
    send_block(64, 24'h0, 1'b1, 1'b1);
    frame_if.ul24Rgb24Data = 24'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b1;
    frame_if.ul1Active = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_avg", avg, 24'h0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_type", otype, MB_INTRA);
    chk("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    send_block(64, 24'h7f8081, 1'b0, 1'b1);
    chk("post_rst_avg", avg, 24'h7f8081);
    chk("post_rst_err", err, 1'b0);
    end_frame(1);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
